// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-memory loader.
//   - state_t          : loader FSM state encoding
//   - ADDR_W_DEF       : default program address width (memory depth 2^ADDR_W)
//   - INSTR_W_DEF      : default instruction width (8 < INSTR_W <= 16)
//   - BYTES_PER_INSTR  : stream bytes packed into one instruction
package prog_loader_pkg;

  localparam int ADDR_W_DEF      = 8;
  localparam int INSTR_W_DEF     = 12;
  localparam int BYTES_PER_INSTR = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a high byte and a low byte into one INSTR_W instruction word.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   byte_in     : stream byte
//   byte_vld    : byte_in is to be taken this cycle
//   sel_lo      : 0 = byte is the high part, 1 = byte is the low part
//   word        : packed instruction {hi[INSTR_W-9:0], lo[7:0]}, held between updates
//   word_valid  : one-cycle strobe, high the cycle after the low byte is taken
module prog_loader_byte_packer
  import prog_loader_pkg::*;
#(
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         byte_in,
  input  logic               byte_vld,
  input  logic               sel_lo,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid
);

  logic [INSTR_W-9:0] hi_p0;

  // Bits of the high byte above the instruction width are dropped on purpose.
  if (INSTR_W < 16) begin : g_unused
    logic unused_hi_bits;
    assign unused_hi_bits = ^byte_in[7:INSTR_W-8];
  end

  // Stage 0: hold high part; stage 1: publish the full word with its strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_p0      <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_vld & sel_lo;
      if (byte_vld && !sel_lo) hi_p0 <= byte_in[INSTR_W-9:0];
      if (byte_vld && sel_lo)  word  <= {hi_p0, byte_in};
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program-memory loader: receives a byte stream over valid/ready, packs byte
// pairs into instructions, writes them to sequential addresses from 0, and
// raises run once a complete load has finished.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   start, len_m1        : begin a session of len_m1+1 instructions
//   abort                : cancel the session in progress
//   in_data/in_valid/in_ready : byte stream handshake
//   load_en/load_addr/load_instr : program memory write port
//   run                  : program memory read enable (program valid)
//   busy, done, aborted  : session status
//   checksum             : mod-256 sum of bytes accepted this session
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  len_m1,
  input  logic               abort,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               load_en,
  output logic [ADDR_W-1:0]  load_addr,
  output logic [INSTR_W-1:0] load_instr,
  output logic               run,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic [7:0]         checksum
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] len_q;
  logic              take_byte;
  logic              word_valid;

  // An aborted cycle consumes the offered byte but must not count or pack it.
  assign take_byte = in_valid & in_ready & ~abort;

  // word_valid is high exactly in the WR cycle; abort suppresses that write.
  assign load_en = word_valid & ~abort;

  prog_loader_byte_packer #(
    .INSTR_W (INSTR_W)
  ) u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (in_data),
    .byte_vld   (take_byte),
    .sel_lo     (state == S_LO),
    .word       (load_instr),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr      <= '0;
      len_q     <= '0;
      load_addr <= '0;
      in_ready  <= 1'b0;
      run       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            len_q    <= len_m1;
            addr     <= '0;
            checksum <= '0;
            run      <= 1'b0;
            aborted  <= 1'b0;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_HI;
          end
        end
        S_HI, S_LO, S_WR: begin
          if (abort) begin
            aborted  <= 1'b1;
            busy     <= 1'b0;
            in_ready <= 1'b0;
            state    <= S_IDLE;
          end else if (state == S_WR) begin
            // Stop at the last address so the counter never wraps.
            if (addr == len_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              addr     <= addr + ADDR_W'(1);
              in_ready <= 1'b1;
              state    <= S_HI;
            end
          end else if (take_byte) begin
            checksum <= checksum + in_data;
            if (state == S_HI) begin
              state <= S_LO;
            end else begin
              load_addr <= addr;
              in_ready  <= 1'b0;
              state     <= S_WR;
            end
          end
        end
        S_DONE: begin
          run   <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [ADDR_W-1:0]  len_m1;
  logic               abort;
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_instr;
  logic               run;
  logic               busy;
  logic               done;
  logic               aborted;
  logic [7:0]         checksum;

  prog_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_m1     (len_m1),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_instr (load_instr),
    .run        (run),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference data: bytes offered this session, and writes seen on the memory port.
  logic [7:0]         tx[$];
  int                 tx_idx;
  logic [ADDR_W-1:0]  wa[$];
  logic [INSTR_W-1:0] wi[$];
  int cyc = 0, done_cnt = 0, acc_cnt = 0, lo_cyc = 0, last_wr_cyc = 0;

  // Expected instruction from a byte pair: high byte keeps only its low INSTR_W-8 bits.
  function automatic int model_instr(input int b0, input int b1);
    return ((b0 % (1 << (INSTR_W - 8))) << 8) + b1;
  endfunction

  function automatic int model_sum(input int nbytes);
    int s = 0;
    for (int i = 0; i < nbytes; i++) s += int'(tx[i]);
    return s % 256;
  endfunction

  // Memory-port monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc++;
    if (rst || (start && !busy)) begin
      wa.delete();
      wi.delete();
      done_cnt = 0;
      acc_cnt  = 0;
    end else begin
      if (in_valid && in_ready && !abort) begin
        acc_cnt++;
        if (acc_cnt % 2 == 0) lo_cyc = cyc;
      end
      if (load_en) begin
        wa.push_back(load_addr);
        wi.push_back(load_instr);
        check("wr_latency", cyc - lo_cyc, 1);
        check("run_low_in_session", {31'd0, run}, 0);
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        check("done_latency", cyc - last_wr_cyc, 1);
      end
    end
  end

  task automatic fill_tx(input int n);
    tx.delete();
    repeat (n) tx.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic start_session(input int len);
    len_m1 = ADDR_W'(len);
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    tx_idx = 0;
  endtask

  // mode 0: always valid, 1: valid pattern 1,0,0,1, other: random valid
  task automatic push_bytes(input int mode, input int n);
    int   sent = 0;
    int   k = 0;
    int   budget = n * 20 + 20;
    logic v;
    while (sent < n && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (k % 4 == 0) || (k % 4 == 3);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = tx[tx_idx];
      @(negedge clk);
      if (in_valid && in_ready) begin
        tx_idx++;
        sent++;
      end
      @(posedge clk); #1;
      k++;
      budget--;
    end
    in_valid = 1'b0;
    if (sent < n) check("push_timeout", sent, n);
  endtask

  task automatic wait_done();
    int b = 0;
    while (done_cnt == 0 && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic verify_session(input int n);
    check("wr_count", wa.size(), n);
    for (int i = 0; i < n && i < wa.size(); i++) begin
      check("wr_addr", {24'd0, wa[i]}, i);
      check("wr_instr", {20'd0, wi[i]}, model_instr(tx[2*i], tx[2*i+1]));
    end
    check("done_pulses", done_cnt, 1);
    check("run_after_load", {31'd0, run}, 1);
    check("aborted_clear", {31'd0, aborted}, 0);
    check("busy_after_load", {31'd0, busy}, 0);
    check("checksum", {24'd0, checksum}, model_sum(2 * n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   {31'd0, in_ready}, 0);
    check({tag, "_load_en"},    {31'd0, load_en}, 0);
    check({tag, "_load_addr"},  {24'd0, load_addr}, 0);
    check({tag, "_load_instr"}, {20'd0, load_instr}, 0);
    check({tag, "_run"},        {31'd0, run}, 0);
    check({tag, "_busy"},       {31'd0, busy}, 0);
    check({tag, "_done"},       {31'd0, done}, 0);
    check({tag, "_aborted"},    {31'd0, aborted}, 0);
    check({tag, "_checksum"},   {24'd0, checksum}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; len_m1 = '0;
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("idle_in_ready", {31'd0, in_ready}, 0);
      check("idle_load_en", {31'd0, load_en}, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Basic load, back-to-back bytes
    tx = '{8'h0A, 8'hBC, 8'h01, 8'h23};
    start_session(1);
    push_bytes(0, 4);
    wait_done();
    verify_session(2);
    check("basic_instr0", {20'd0, wi[0]}, 32'hABC);
    check("basic_checksum", {24'd0, checksum}, 32'hEA);

    // Same data with a stalling source
    tx = '{8'h0A, 8'hBC, 8'h01, 8'h23};
    start_session(1);
    push_bytes(1, 4);
    wait_done();
    verify_session(2);

    // Unused upper bits of the high byte are masked but still summed
    tx = '{8'hF5, 8'h67};
    start_session(0);
    push_bytes(0, 2);
    wait_done();
    verify_session(1);
    check("mask_instr", {20'd0, wi[0]}, 32'h567);
    check("mask_checksum", {24'd0, checksum}, 32'h5C);

    // start while busy is ignored (len stays 1)
    fill_tx(4);
    start_session(1);
    push_bytes(0, 2);
    len_m1 = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_bytes(2, 2);
    wait_done();
    verify_session(2);

    // Abort in HI after two writes, with a byte offered on the abort cycle
    fill_tx(8);
    start_session(3);
    push_bytes(0, 4);
    @(posedge clk); #1;
    abort = 1'b1; in_valid = 1'b1; in_data = tx[4];
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_flag", {31'd0, aborted}, 1);
    check("abort_run", {31'd0, run}, 0);
    check("abort_in_ready", {31'd0, in_ready}, 0);
    check("abort_checksum", {24'd0, checksum}, model_sum(4));
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_wr_count", wa.size(), 2);
    for (int i = 0; i < 2 && i < wa.size(); i++) begin
      check("abort_wr_addr", {24'd0, wa[i]}, i);
      check("abort_wr_instr", {20'd0, wi[i]}, model_instr(tx[2*i], tx[2*i+1]));
    end
    check("abort_sticky", {31'd0, aborted}, 1);

    // A new start clears the sticky abort flag
    start_session(0);
    check("restart_aborted", {31'd0, aborted}, 0);
    check("restart_run", {31'd0, run}, 0);
    push_bytes(2, 2);
    wait_done();
    verify_session(1);

    // Abort during WR suppresses the write
    fill_tx(2);
    start_session(0);
    push_bytes(0, 2);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_wr_writes", wa.size(), 0);
    check("abort_wr_flag", {31'd0, aborted}, 1);
    check("abort_wr_run", {31'd0, run}, 0);
    check("abort_wr_done", done_cnt, 0);
    check("abort_wr_checksum", {24'd0, checksum}, model_sum(2));

    // Asynchronous reset while in LO
    fill_tx(12);
    start_session(5);
    push_bytes(0, 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;

    // Full depth: every address written once, in order
    fill_tx(512);
    start_session(255);
    push_bytes(2, 512);
    wait_done();
    verify_session(256);

    // Random sessions
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 16);
      fill_tx(2 * n);
      start_session(n - 1);
      push_bytes(r % 3, 2 * n);
      wait_done();
      verify_session(n);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
